// File: rtl/image_window_ctrl_pkg.sv
// image_window_ctrl_pkg: shared geometry and read-FSM encoding for the 3x3 window controller.
package image_window_ctrl_pkg;
    localparam int IMG_WIDTH = 512;
    localparam int NUM_LB    = 4;
    localparam int CNT_W     = 12;
    localparam int PIX_W     = 8;
    localparam int ADDR_W    = $clog2(IMG_WIDTH);
    typedef enum logic {IDLE = 1'b0, READ = 1'b1} rd_state_t;
endpackage

// File: rtl/image_window_ctrl_line_buffer.sv
// image_window_ctrl_line_buffer: one image line of storage; presents three adjacent pixels at the read pointer.
module image_window_ctrl_line_buffer
    import image_window_ctrl_pkg::*;
(
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic [PIX_W-1:0]     in_data,
    input  logic                 in_data_valid,
    input  logic                 in_read_data,
    output logic [3*PIX_W-1:0]   out_data
);
    logic [PIX_W-1:0]  mem [IMG_WIDTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    always_ff @(posedge in_clk) begin
        if (in_data_valid) mem[wr_ptr] <= in_data;
    end
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (in_data_valid) wr_ptr <= wr_ptr + 1'b1;
            if (in_read_data) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    // Pointer arithmetic wraps, so the last two windows of a line pick up addresses 0/1.
    assign out_data = {mem[rd_ptr], mem[rd_ptr + ADDR_W'(1)], mem[rd_ptr + ADDR_W'(2)]};
endmodule

// File: rtl/image_window_ctrl.sv
// image_window_ctrl: round-robins a pixel stream into four line buffers and streams 3x3 windows
// from three of them while the fourth fills.
module image_window_ctrl
    import image_window_ctrl_pkg::*;
(
    input  logic               in_clk,
    input  logic               in_rst,
    input  logic [PIX_W-1:0]   in_data,
    input  logic               in_data_valid,
    output logic [9*PIX_W-1:0] out_pixel_data,
    output logic               out_pixel_data_valid,
    output logic               out_intr,
    output logic               out_overflow
);
    localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(IMG_WIDTH - 1);
    localparam logic [CNT_W-1:0]  START_CNT = CNT_W'(3 * IMG_WIDTH);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(NUM_LB * IMG_WIDTH);

    rd_state_t          state;
    logic [CNT_W-1:0]   buffered_cnt;
    logic [ADDR_W-1:0]  wr_pix_cnt;
    logic [ADDR_W-1:0]  rd_pix_cnt;
    logic [1:0]         wr_sel;
    logic [1:0]         rd_sel;
    logic               wr_accept;
    logic               rd_active;
    logic [NUM_LB-1:0]  lb_wr;
    logic [NUM_LB-1:0]  lb_rd;
    logic [3*PIX_W-1:0] lb_out [NUM_LB];

    assign wr_accept = in_data_valid && (buffered_cnt < FULL_CNT);
    assign rd_active = (state == READ);

    for (genvar i = 0; i < NUM_LB; i++) begin : g_lb
        assign lb_wr[i] = wr_accept && (wr_sel == 2'(i));
        // The buffer three slots after rd_sel is the one currently filling.
        assign lb_rd[i] = rd_active && ((rd_sel + 2'd3) != 2'(i));
        image_window_ctrl_line_buffer u_lb (
            .in_clk        (in_clk),
            .in_rst        (in_rst),
            .in_data       (in_data),
            .in_data_valid (lb_wr[i]),
            .in_read_data  (lb_rd[i]),
            .out_data      (lb_out[i])
        );
    end

    assign out_pixel_data       = {lb_out[rd_sel], lb_out[rd_sel + 2'd1], lb_out[rd_sel + 2'd2]};
    assign out_pixel_data_valid = rd_active;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state        <= IDLE;
            buffered_cnt <= '0;
            wr_pix_cnt   <= '0;
            rd_pix_cnt   <= '0;
            wr_sel       <= '0;
            rd_sel       <= '0;
            out_intr     <= 1'b0;
            out_overflow <= 1'b0;
        end else begin
            out_intr <= 1'b0;
            if (in_data_valid && !wr_accept) out_overflow <= 1'b1;
            if (wr_accept) begin
                wr_pix_cnt <= wr_pix_cnt + 1'b1;
                if (wr_pix_cnt == LAST_PIX) wr_sel <= wr_sel + 1'b1;
            end
            if (wr_accept != rd_active) buffered_cnt <= wr_accept ? buffered_cnt + 1'b1 : buffered_cnt - 1'b1;
            if (state == IDLE) begin
                if (buffered_cnt >= START_CNT) state <= READ;
            end else begin
                rd_pix_cnt <= rd_pix_cnt + 1'b1;
                if (rd_pix_cnt == LAST_PIX) begin
                    rd_sel   <= rd_sel + 1'b1;
                    state    <= IDLE;
                    out_intr <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_image_window_ctrl.sv
// tb_image_window_ctrl: directed checks of fill, line read, window contents, overflow and mid-read reset.
module tb_image_window_ctrl;
    import image_window_ctrl_pkg::*;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic [7:0]  in_data;
    logic        in_data_valid;
    logic [71:0] out_pixel_data;
    logic        out_pixel_data_valid;
    logic        out_intr;
    logic        out_overflow;

    int checks = 0;
    int failures = 0;
    int intr_cnt = 0;
    int valid_cnt = 0;
    logic prev_v = 1'b0;
    logic [71:0] wins [$];

    image_window_ctrl dut (
        .in_clk               (in_clk),
        .in_rst               (in_rst),
        .in_data              (in_data),
        .in_data_valid        (in_data_valid),
        .out_pixel_data       (out_pixel_data),
        .out_pixel_data_valid (out_pixel_data_valid),
        .out_intr             (out_intr),
        .out_overflow         (out_overflow)
    );

    always #5 in_clk = ~in_clk;

    always @(negedge in_clk) begin
        if (out_intr) intr_cnt++;
        if (out_pixel_data_valid) valid_cnt++;
        if (out_pixel_data_valid && !prev_v) wins.push_back(out_pixel_data);
        prev_v = out_pixel_data_valid;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        in_data = v;
        in_data_valid = 1'b1;
        tick();
    endtask

    function automatic logic [7:0] pix(input int k, input int off);
        return 8'((k / 512) * 16 + (k % 512) + off);
    endfunction

    function automatic logic [71:0] win(input int i);
        return (wins.size() > i) ? wins[i] : 'x;
    endfunction

    initial begin
        int n;
        int ov_state;
        int base;
        logic [11:0] c0;
        in_rst = 1'b1;
        in_data = '0;
        in_data_valid = 1'b0;
        repeat (3) tick();
        in_rst = 1'b0;
        check("rst_valid", 72'(out_pixel_data_valid), 72'd0);
        check("rst_intr", 72'(out_intr), 72'd0);
        check("rst_ovf", 72'(out_overflow), 72'd0);
        check("rst_cnt", 72'(dut.buffered_cnt), 72'd0);

        for (int k = 0; k < 1535; k++) push(pix(k, 0));
        in_data_valid = 1'b0;
        repeat (3) tick();
        check("fill1535_valid", 72'(valid_cnt), 72'd0);
        check("fill1535_cnt", 72'(dut.buffered_cnt), 72'd1535);

        push(pix(1535, 0));
        in_data_valid = 1'b0;
        check("valid_before_start", 72'(out_pixel_data_valid), 72'd0);
        tick();
        check("valid_start", 72'(out_pixel_data_valid), 72'd1);
        check("first_window", out_pixel_data, 72'h000102_101112_202122);
        for (n = 1; n < 600; n++) begin
            tick();
            if (!out_pixel_data_valid) break;
            if (n == 510) check("right_edge_window", out_pixel_data, 72'hFEFF00_0E0F10_1E1F20);
        end
        check("line_len", 72'(n), 72'd512);
        check("intr_after_line", 72'(out_intr), 72'd1);
        tick();
        check("intr_one_cycle", 72'(out_intr), 72'd0);
        check("cnt_after_line", 72'(dut.buffered_cnt), 72'd1024);
        check("intr_cnt_1", 72'(intr_cnt), 72'd1);

        ov_state = 0;
        c0 = '0;
        for (int k = 1536; k < 3072; k++) begin
            if (ov_state == 0 && out_pixel_data_valid) begin
                c0 = dut.buffered_cnt;
                ov_state = 1;
            end else if (ov_state == 1) begin
                check("cnt_overlap", 72'(dut.buffered_cnt), 72'(c0));
                ov_state = 2;
            end
            push(pix(k, 0));
        end
        in_data_valid = 1'b0;
        repeat (600) tick();
        check("overlap_seen", 72'(ov_state), 72'd2);
        check("intr_cnt_4", 72'(intr_cnt), 72'd4);
        check("valid_cnt_4", 72'(valid_cnt), 72'd2048);
        check("num_lines", 72'(wins.size()), 72'd4);
        check("win_rd_sel1", win(1), 72'h101112_202122_303132);
        check("win_rd_sel2", win(2), 72'h202122_303132_404142);
        check("win_rd_sel3", win(3), 72'h303132_404142_505152);
        check("cnt_after_6", 72'(dut.buffered_cnt), 72'd1024);
        check("no_ovf_stream", 72'(out_overflow), 72'd0);

        in_rst = 1'b1;
        tick();
        force dut.state = IDLE;
        in_rst = 1'b0;
        for (int k = 0; k < 2048; k++) push(8'(k));
        check("full_no_ovf", 72'(out_overflow), 72'd0);
        check("full_cnt", 72'(dut.buffered_cnt), 72'd2048);
        push(8'hAA);
        in_data_valid = 1'b0;
        check("ovf_set", 72'(out_overflow), 72'd1);
        check("ovf_cnt", 72'(dut.buffered_cnt), 72'd2048);
        check("ovf_wr_sel", 72'(dut.wr_sel), 72'd0);
        check("ovf_wr_pix", 72'(dut.wr_pix_cnt), 72'd0);
        repeat (3) tick();
        check("ovf_sticky", 72'(out_overflow), 72'd1);
        release dut.state;
        in_rst = 1'b1;
        tick();
        check("ovf_cleared", 72'(out_overflow), 72'd0);
        in_rst = 1'b0;

        for (int k = 0; k < 1536; k++) push(pix(k, 0));
        in_data_valid = 1'b0;
        tick();
        check("rerun_valid", 72'(out_pixel_data_valid), 72'd1);
        repeat (200) tick();
        check("read_cycle200", 72'(dut.rd_pix_cnt), 72'd200);
        base = intr_cnt;
        in_rst = 1'b1;
        tick();
        in_rst = 1'b0;
        check("midrst_valid", 72'(out_pixel_data_valid), 72'd0);
        check("midrst_intr", 72'(out_intr), 72'd0);
        check("midrst_cnt", 72'(dut.buffered_cnt), 72'd0);
        check("midrst_rd_pix", 72'(dut.rd_pix_cnt), 72'd0);
        check("midrst_rd_sel", 72'(dut.rd_sel), 72'd0);
        check("midrst_wr_sel", 72'(dut.wr_sel), 72'd0);
        repeat (3) tick();
        check("midrst_no_intr", 72'(intr_cnt), 72'(base));

        for (int k = 0; k < 1536; k++) push(pix(k, 8));
        in_data_valid = 1'b0;
        for (n = 0; n < 5 && !out_pixel_data_valid; n++) tick();
        check("refill_valid", 72'(out_pixel_data_valid), 72'd1);
        check("refill_window", out_pixel_data, 72'h08090A_18191A_28292A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
